// File: rtl/wb_write_arbiter_pkg.sv
// Shared constants and the write-source selection used by the write-back arbiter.
// Mirrors the defines.vh constants so the arbiter slice compiles standalone.
package wb_write_arbiter_pkg;
  localparam int DATALENGTH    = 32;
  localparam int R_SIZE        = 5;
  localparam int REGNUM        = 1 << R_SIZE;
  localparam logic [DATALENGTH-1:0] ZEROWORD = '0;
  localparam int WB_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_FIFO,
    WB_BYPASS
  } wb_src_e;

  // ALU first, then the oldest buffered load, then a load arriving this cycle.
  function automatic wb_src_e wb_select(input logic alu_win, input logic fifo_empty,
                                        input logic ld_direct);
    wb_src_e s;
    s = WB_NONE;
    if (alu_win)          s = WB_ALU;
    else if (!fifo_empty) s = WB_FIFO;
    else if (ld_direct)   s = WB_BYPASS;
    return s;
  endfunction
endpackage

// File: rtl/wb_load_fifo.sv
// In-order buffer for load responses that lost write-port arbitration.
// Pointers wrap naturally because DEPTH is a power of two.
module wb_load_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH,
  parameter int AW    = R_SIZE,
  parameter int DW    = DATALENGTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [AW-1:0]            push_dest,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [AW-1:0]            head_dest,
  output logic [DW-1:0]            head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW+DW-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign {head_dest, head_data} = mem[rd_ptr];

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= {push_dest, push_data};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: ALU write-back has priority, load responses
// are written directly or buffered, and a pending mask tracks outstanding loads.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH,
  parameter int DW    = DATALENGTH,
  parameter int AW    = R_SIZE
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [AW-1:0]            alu_dest,
  input  logic [DW-1:0]            alu_data,
  input  logic                     ld_issue,
  input  logic [AW-1:0]            ld_issue_dest,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_dest,
  input  logic [DW-1:0]            ld_data,
  output logic                     ld_ready,
  output logic                     RegWriteW,
  output logic [AW-1:0]            A3,
  output logic [DW-1:0]            WD3,
  output logic [(2**AW)-1:0]       pending_mask,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int NREG = 2 ** AW;

  logic            fifo_full, fifo_empty;
  logic [AW-1:0]   head_dest;
  logic [DW-1:0]   head_data;
  logic            ld_xfer, ld_keep, alu_win, ld_write, push, pop;
  wb_src_e         src;
  logic [AW-1:0]   wdest;
  logic [DW-1:0]   wdata;
  logic [NREG-1:0] set_vec, clr_vec;

  assign ld_ready = !reset && !fifo_full;
  assign ld_xfer  = ld_valid && ld_ready;
  assign ld_keep  = ld_xfer && (ld_dest != '0);
  assign alu_win  = alu_valid && (alu_dest != '0);

  assign src      = wb_select(alu_win, fifo_empty, ld_keep);
  assign pop      = (src == WB_FIFO);
  assign push     = ld_keep && (src != WB_BYPASS);
  assign ld_write = (src == WB_FIFO) || (src == WB_BYPASS);

  always_comb begin
    wdest = '0;
    wdata = '0;
    case (src)
      WB_ALU:    begin wdest = alu_dest;  wdata = alu_data;  end
      WB_FIFO:   begin wdest = head_dest; wdata = head_data; end
      WB_BYPASS: begin wdest = ld_dest;   wdata = ld_data;   end
      default:   ;
    endcase
  end

  wb_load_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_dest (ld_dest),
    .push_data (ld_data),
    .pop       (pop),
    .head_dest (head_dest),
    .head_data (head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A3/WD3 hold their last value on idle cycles; only RegWriteW drops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      RegWriteW <= 1'b0;
      A3        <= '0;
      WD3       <= DW'(ZEROWORD);
    end else begin
      RegWriteW <= (src != WB_NONE);
      if (src != WB_NONE) begin
        A3  <= wdest;
        WD3 <= wdata;
      end
    end
  end

  // Register 0 is never tracked; a new issue wins over a same-edge retire.
  for (genvar i = 0; i < NREG; i++) begin : g_pend
    if (i == 0) begin : g_zero
      assign set_vec[i] = 1'b0;
      assign clr_vec[i] = 1'b0;
    end else begin : g_reg
      assign set_vec[i] = ld_issue && (ld_issue_dest == AW'(i));
      assign clr_vec[i] = ld_write && (wdest == AW'(i));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pending_mask <= '0;
    else       pending_mask <= (pending_mask & ~clr_vec) | set_vec;
  end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Randomized and directed bench for wb_write_arbiter against a queue-based model.
module tb_wb_write_arbiter;
  localparam int DEPTH = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          alu_valid, ld_issue, ld_valid;
  logic [AW-1:0] alu_dest, ld_issue_dest, ld_dest;
  logic [DW-1:0] alu_data, ld_data;
  logic          ld_ready, RegWriteW;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD3;
  logic [31:0]   pending_mask;
  logic [2:0]    fifo_count;

  int total = 0;
  int bad = 0;

  logic [AW+DW-1:0] q[$];
  logic [AW-1:0]    outst[$];
  logic [31:0]      mmask;
  bit               ew, acc;
  logic [AW-1:0]    ea;
  logic [DW-1:0]    ed;

  always #5 clock = ~clock;

  wb_write_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_dest(ld_issue_dest),
    .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_data(ld_data),
    .ld_ready(ld_ready), .RegWriteW(RegWriteW), .A3(A3), .WD3(WD3),
    .pending_mask(pending_mask), .fifo_count(fifo_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 0; ld_issue = 0; ld_valid = 0;
    alu_dest = '0; ld_issue_dest = '0; ld_dest = '0;
    alu_data = '0; ld_data = '0;
  endtask

  // One clock: model decides this edge's write from the priority rules, then compare.
  task automatic cycle();
    bit rdy, xfer, byp;
    logic [AW+DW-1:0] e;
    logic [31:0] setv, clrv;
    #1;
    rdy = (q.size() < DEPTH);
    chk("ld_ready", ld_ready, rdy);
    if (alu_valid) chk("alu_raw", pending_mask[alu_dest], 0);
    xfer = ld_valid && rdy;
    acc = xfer;
    clrv = '0; setv = '0; byp = 0;
    if (alu_valid && alu_dest != 0) begin
      ew = 1; ea = alu_dest; ed = alu_data;
    end else if (q.size() > 0) begin
      e = q.pop_front(); ew = 1; ea = e[AW+DW-1:DW]; ed = e[DW-1:0]; clrv[ea] = 1'b1;
    end else if (xfer && ld_dest != 0) begin
      ew = 1; ea = ld_dest; ed = ld_data; clrv[ea] = 1'b1; byp = 1;
    end else ew = 0;
    if (xfer && ld_dest != 0 && !byp) q.push_back({ld_dest, ld_data});
    if (ld_issue && ld_issue_dest != 0) setv[ld_issue_dest] = 1'b1;
    mmask = (mmask & ~clrv) | setv;
    @(posedge clock); #1;
    chk("we", RegWriteW, ew);
    if (ew) begin
      chk("a3", A3, ea);
      chk("wd3", WD3, ed);
    end
    chk("count", fifo_count, q.size());
    chk("mask", pending_mask, mmask);
  endtask

  initial begin
    int nacc;
    int r, r2, idx, busy;
    idle();
    mmask = '0; acc = 1;
    reset = 1;
    #2;
    chk("rst_we", RegWriteW, 0); chk("rst_a3", A3, 0); chk("rst_wd3", WD3, 0);
    chk("rst_mask", pending_mask, 0); chk("rst_cnt", fifo_count, 0);
    chk("rst_rdy", ld_ready, 0);
    #11 reset = 0;

    // direct load write with the ALU idle
    ld_valid = 1; ld_dest = 5; ld_data = 32'h1234;
    cycle();
    chk("byp_we", RegWriteW, 1); chk("byp_a3", A3, 5);
    chk("byp_wd3", WD3, 32'h1234); chk("byp_cnt", fifo_count, 0);
    idle(); cycle();

    // pending bit lifetime
    ld_issue = 1; ld_issue_dest = 8; cycle(); idle();
    chk("pend_t1", pending_mask[8], 1);
    cycle(); chk("pend_t2", pending_mask[8], 1);
    cycle(); chk("pend_t3", pending_mask[8], 1);
    ld_valid = 1; ld_dest = 8; ld_data = 32'hbeef; cycle(); idle();
    chk("pend_wr_a3", A3, 8); chk("pend_wr_clr", pending_mask[8], 0);
    cycle(); chk("pend_after", pending_mask[8], 0);

    // ALU saturates the port; loads 1..5 back-to-back fill the FIFO
    nacc = 0; r = 1;
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1; alu_dest = AW'(20 + c); alu_data = 32'hA000 + c;
      ld_valid = (r <= 5); ld_dest = AW'(r); ld_data = 32'hD000 + r;
      cycle();
      if (acc && r <= 5) begin nacc++; r++; end
    end
    chk("acc4", nacc, 4);
    alu_valid = 0;
    for (int k = 1; k <= 5; k++) begin
      ld_valid = (r <= 5); ld_dest = AW'(r); ld_data = 32'hD000 + r;
      cycle();
      if (acc && r <= 5) r++;
      chk("order_we", RegWriteW, 1); chk("order_a3", A3, k);
    end
    idle(); cycle();

    // dest 0 writes are dropped
    alu_valid = 1; alu_dest = 0; alu_data = 32'h1;
    ld_valid = 1; ld_dest = 0; ld_data = 32'h2;
    cycle();
    chk("z_we", RegWriteW, 0); chk("z_cnt", fifo_count, 0); chk("z_mask", pending_mask, 0);
    idle(); cycle();

    // issue to 9 on the same edge that retires the older load to 9
    ld_issue = 1; ld_issue_dest = 9; cycle(); idle(); cycle();
    ld_valid = 1; ld_dest = 9; ld_data = 32'h99; ld_issue = 1; ld_issue_dest = 9;
    cycle(); idle();
    chk("sw_a3", A3, 9); chk("sw_mask", pending_mask[9], 1);
    ld_valid = 1; ld_dest = 9; ld_data = 32'h999; cycle(); idle();
    chk("sw_clr", pending_mask[9], 0);
    cycle();

    // asynchronous reset with three buffered loads
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1; alu_dest = 20; alu_data = 32'h5;
      ld_valid = 1; ld_dest = AW'(c + 1); ld_data = 32'h70 + c;
      cycle();
    end
    chk("pre_rst_cnt", fifo_count, 3);
    idle();
    #2 reset = 1;
    #1;
    chk("arst_we", RegWriteW, 0); chk("arst_cnt", fifo_count, 0);
    chk("arst_mask", pending_mask, 0); chk("arst_rdy", ld_ready, 0);
    chk("arst_a3", A3, 0); chk("arst_wd3", WD3, 0);
    q.delete(); mmask = '0;
    @(posedge clock); #4 reset = 0;
    for (int c = 0; c < 4; c++) cycle();

    // randomized traffic with varying ALU pressure
    idle(); acc = 1; busy = 2;
    for (int n = 0; n < 2000; n++) begin
      if (n % 100 == 0) busy = $urandom_range(0, 4);
      if (!(ld_valid && !acc)) begin
        if (outst.size() > 0 && $urandom_range(0, 2) != 0) begin
          idx = $urandom_range(0, outst.size() - 1);
          ld_dest = outst[idx]; outst.delete(idx);
          ld_valid = 1; ld_data = $urandom;
        end else if ($urandom_range(0, 9) == 0) begin
          ld_valid = 1; ld_dest = 0; ld_data = $urandom;
        end else ld_valid = 0;
      end
      r2 = $urandom_range(0, 31);
      alu_valid = ($urandom_range(0, 3) < busy) && !mmask[r2];
      alu_dest = AW'(r2); alu_data = $urandom;
      r = $urandom_range(0, 31);
      ld_issue = ($urandom_range(0, 2) == 0) && !mmask[r];
      ld_issue_dest = AW'(r);
      if (ld_issue && r != 0) outst.push_back(AW'(r));
      cycle();
    end
    idle();
    for (int c = 0; c < 8; c++) cycle();
    chk("end_cnt", fifo_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Write-back arbiter that drives the single register-file write port (RegWriteW/A3/WD3) from two producers: the in-order ALU write-back pipe (one result per cycle, never stalls) and the variable-latency AXI load-response path. Load responses that lose arbitration are buffered in a small FIFO. The block also maintains a per-register pending-load mask that decode uses to stall RAW and WAW hazards on outstanding loads. It sits between the MEM/WB stage and regfile, and is the writer side of the regfile's write port.

## Interface
- DEPTH, 4: load FIFO entries; power of two, ≥2
- DW, 32: data width (`DATALENGTH)
- AW, 5: register index width (`R_SIZE)
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- alu_valid  in  1  ALU result present this cycle
- alu_dest  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- ld_issue  in  1  load accepted into MEM this cycle; marks dest pending
- ld_issue_dest  in  AW  destination of issued load
- ld_valid  in  1  load response valid (data already extended)
- ld_dest  in  AW  load response destination
- ld_data  in  DW  load response data
- ld_ready  out  1  arbiter accepts load response
- RegWriteW  out  1  regfile write enable (registered)
- A3  out  AW  regfile write address (registered)
- WD3  out  DW  regfile write data (registered)
- pending_mask  out  2**AW  bit i set = load to reg i outstanding
- fifo_count  out  clog2(DEPTH)+1  FIFO occupancy

## Operation
- Load handshake: a response transfers when ld_valid && ld_ready. ld_ready = (fifo_count < DEPTH), and ld_ready = 0 while reset is asserted.
- Arbitration each cycle, in priority order. At most one write is registered per cycle.
  - ALU: alu_valid with alu_dest≠0 → write ALU.
  - Else, FIFO non-empty → pop head and write it.
  - Else, a transferring load with ld_dest≠0 → write it directly (bypass, no FIFO occupancy).
  - Else RegWriteW ← 0.
- Transferring loads that are not written this cycle are pushed to the FIFO tail. Push and pop may occur in the same cycle; the count is unchanged.
- A full FIFO with the ALU winning still accepts no load (ld_ready = 0). Pop occurs only when the ALU is idle.
- dest = 0: an ALU or load write is discarded (never reaches the port, never enters the FIFO). ld_issue with dest 0 does not set a pending bit.
- pending_mask: bit set at the edge of ld_issue; bit cleared at the edge where that load's write is registered (RegWriteW=1, A3=dest). If set and clear hit the same bit in one cycle, set wins.
- Ordering: the FIFO drains strictly in order. Upstream guarantees that no ALU or ld_issue targets a register whose pending bit is set. The bench asserts alu_valid && pending_mask[alu_dest] never occurs.
- When the ALU is idle, the load path is served, so FIFO residence is unbounded only under continuous ALU writes.

## Timing
- Reset values: RegWriteW=0, A3=0, WD3=`ZEROWORD, pending_mask=0, fifo_count=0, FIFO pointers=0, ld_ready=0 during reset.
- Latency from acceptance (ALU valid or load transfer) to RegWriteW high is 1 cycle minimum. Buffered loads wait +1 cycle per ALU-occupied cycle ahead of them.
- A pending bit drops in the same cycle RegWriteW presents the write. The regfile's same-cycle WD3 forwarding covers the decode read in that cycle.
- Reset mid-operation: FIFO contents and pending bits are lost immediately. Outputs return to reset values asynchronously.

## Structure
- Use the shared defines.vh constants `DATALENGTH, `R_SIZE, `REGNUM, `ZEROWORD. Add `WB_FIFO_DEPTH there.
- Sub-module wb_load_fifo holds the DEPTH×(AW+DW) storage, wrap-around pointers, count, full, and empty.
- The top level contains the arbitration mux, output registers, and the pending_mask register.

## Test plan
- Reset, then ld_valid, ld_dest=5, ld_data=0x1234 with the ALU idle → next cycle RegWriteW=1, A3=5, WD3=0x1234, fifo_count=0.
- ld_issue dest 8 at t0; ld response at t3 → pending_mask[8] is 1 from t1 through t3. It is 0 in the cycle RegWriteW shows A3=8, then stays 0.
- alu_valid continuously for 6 cycles; ld responses dest 1–5 back-to-back → ld_ready drops after 4 accepted. After the ALU stops, writes 1, 2, 3, 4, 5 appear in order on consecutive cycles.
- ALU dest 0 and load dest 0 → RegWriteW stays 0, FIFO empty, mask unchanged.
- Simultaneous ld_issue dest 9 and the write of an earlier load to dest 9 → pending_mask[9] remains 1.
- Assert reset with fifo_count=3 → outputs and count zero immediately. After release, no stale writes occur.
